multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I core; sits directly upstream of the ALU decoder.
- Decodes the opcode from the instruction register and sequences fetch / decode / execute / memory / writeback.
- Drives ALUOp into the ALU decoder and all datapath mux selects and write enables.
- Stalls on a memory ready handshake and halts on unsupported instructions.

Parameters:
- RESET_STATE_FETCH, 1, must be 1: reset lands in FETCH. Kept as a parameter for bench visibility only.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- alu_op  output  2  to ALU decoder: 00 add, 01 subtract, 10 funct-decoded
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4
- result_src  output  2  00 ALUOut, 01 mem data, 10 ALU result
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- adr_src  output  1  0 PC, 1 ALUOut
- pc_write  output  1  PC register enable
- ir_write  output  1  IR / OldPC enable
- mem_write  output  1  data memory write strobe
- reg_write  output  1  register file write enable
- instr_done  output  1  one-cycle retire pulse
- halted  output  1  trap indication
- instret  output  32  retired-instruction count (optional feature)

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to FETCH.
  - pc_write, ir_write, mem_write, reg_write, instr_done and halted read 0 while rst_n is low.
  - Other outputs take their FETCH values.
  - Deassertion is sampled on the next clk edge.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011 (funct3 must be 000), jal 1101111.
- imm_src: combinational from op — I for lw / I-ALU, S for sw, B for beq, J for jal, 00 otherwise.
- Control values below are Moore per state unless noted. Unlisted selects are 00; unlisted enables are 0.
- FETCH:
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write = mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state: lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; beq -> BEQ; jal -> JAL; anything else -> TRAP.
- MEMADR: drives alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: drives adr_src=1, result_src=00. Holds until mem_ready=1, then MEMWB.
- MEMWB: drives result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE:
  - Drives adr_src=1 and mem_write=1, held every cycle until mem_ready=1.
  - instr_done=mem_ready. Next: FETCH once mem_ready=1.
- EXECUTER: drives alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECUTEI: drives alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: drives result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=zero; instr_done=1. Next: FETCH.
- JAL: drives alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next: ALUWB (writes PC+4 to rd).
- TRAP: halted=1; all enables 0; absorbing state. Only rst_n exits it.
- Latency with mem_ready tied high, in cycles FETCH to retire: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Each wait cycle on mem_ready adds one cycle.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction aborts it: no enable pulses, no instr_done, no instret increment.
- State register uses binary encoding; unreachable encodings recover to FETCH.

Optional Feature:
- Macro: PERF_INSTRET_EN.
- Defined:
  - instret is a 32-bit register, reset to 0.
  - Increments on every clk edge where instr_done=1.
  - Wraps 0xFFFFFFFF -> 0x00000000.
- Undefined: instret is tied to 32'h0 and no counter flops are synthesised.

Test Plan:
- add x3,x1,x2 (op 0110011), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. alu_op=10 in EXECUTER; reg_write and instr_done high only in cycle 4.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> ir_write pulses once, on the ready cycle. Retires in cycle 10; result_src=01 in MEMWB.
- sw with mem_ready low 2 cycles in MEMWRITE -> mem_write high 3 consecutive cycles, then FETCH. instr_done pulses once.
- beq twice -> zero=1: pc_write=1 in BEQ, alu_op=01. zero=0: pc_write=0. Both retire in 3 cycles.
- op=1110011 (unsupported) -> TRAP after DECODE; halted=1 held for 20 cycles. rst_n low clears halted asynchronously; next state is FETCH.
- rst_n pulsed low during MEMADR of a sw -> no mem_write; instret (PERF_INSTRET_EN) unchanged. Separately, instret preloaded via force to 0xFFFFFFFF plus one retire reads 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. Decodes the opcode held in
//   the instruction register and sequences fetch / decode / execute / memory /
//   writeback. It drives ALUOp into the ALU decoder, plus every datapath mux
//   select and write enable.
//
// Optional feature macro: PERF_INSTRET_EN
//   Defined   : instret is a 32-bit retired-instruction counter (wraps).
//   Undefined : instret is tied to zero and no counter flops exist.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   op         in   instr[6:0]
//   funct3     in   instr[14:12]
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   alu_op     out  00 add, 01 subtract, 10 funct-decoded
//   alu_src_a  out  00 PC, 01 OldPC, 10 rs1
//   alu_src_b  out  00 rs2, 01 imm, 10 constant 4
//   result_src out  00 ALUOut, 01 mem data, 10 ALU result
//   imm_src    out  00 I, 01 S, 10 B, 11 J
//   adr_src    out  0 PC, 1 ALUOut
//   pc_write   out  PC register enable
//   ir_write   out  IR / OldPC enable
//   mem_write  out  data memory write strobe
//   reg_write  out  register file write enable
//   instr_done out  one-cycle retire pulse
//   halted     out  trap indication
//   instret    out  retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic        adr_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        instr_done,
  output logic        halted,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  // FETCH is the only legal landing state; the parameter exists for visibility.
  localparam logic [3:0] S_RESET = (RESET_STATE_FETCH == 1) ? S_FETCH : S_FETCH;

  logic [3:0] state_q, state_d;

  // Per-state enables before reset gating.
  logic pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic instr_done_raw, halted_raw;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready only matters in FETCH, MEMREAD and MEMWRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ: begin
            if (funct3 == 3'b000) state_d = S_BEQ;
            else                  state_d = S_TRAP;
          end
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW) state_d = S_MEMWRITE;
        else             state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMREAD;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWRITE;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state control outputs (Moore, except the mem_ready / zero terms).
  always_comb begin
    alu_op         = 2'b00;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    result_src     = 2'b00;
    adr_src        = 1'b0;
    pc_write_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    halted_raw     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src     = 2'b01;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src        = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_BEQ: begin
        alu_src_a      = 2'b10;
        alu_op         = 2'b01;
        pc_write_raw   = zero;
        instr_done_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_TRAP: begin
        halted_raw = 1'b1;
      end
      default: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = 2'b00;
      OP_SW:       imm_src = 2'b01;
      OP_BEQ:      imm_src = 2'b10;
      OP_JAL:      imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  // The state flop already sits in FETCH during reset, but FETCH's enables
  // follow mem_ready, so they are masked to keep the datapath quiet.
  assign pc_write   = pc_write_raw   & rst_n;
  assign ir_write   = ir_write_raw   & rst_n;
  assign mem_write  = mem_write_raw  & rst_n;
  assign reg_write  = reg_write_raw  & rst_n;
  assign instr_done = instr_done_raw & rst_n;
  assign halted     = halted_raw     & rst_n;

`ifdef PERF_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  // Retire counter next value; wraps naturally at 32 bits.
  always_comb begin
    if (instr_done) instret_d = instret_q + 32'd1;
    else            instret_d = instret_q;
  end

  // Retire counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 32'h0000_0000;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Table-driven directed bench for multicycle_controller. Each table record is
//   one clock cycle: the inputs for that cycle and the control word expected
//   while in that cycle's state. Hand-written sequences cover the trap, async
//   reset and instret wrap cases.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic        adr_src, pc_write, ir_write, mem_write, reg_write, instr_done, halted;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'h0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  multicycle_controller #(.RESET_STATE_FETCH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .adr_src    (adr_src),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Control word: {alu_op, src_a, src_b, result_src, imm_src, adr, pcw, irw, memw, regw, done, halted}
  function automatic logic [16:0] e(input logic [1:0] aop, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] res,
                                    input logic [1:0] imm, input logic adr,
                                    input logic pcw, input logic irw, input logic mw,
                                    input logic rw, input logic dn, input logic hl);
    return {aop, a, b, res, imm, adr, pcw, irw, mw, rw, dn, hl};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_LW || o == OP_I) return 2'b00;
    if (o == OP_SW)              return 2'b01;
    if (o == OP_BEQ)             return 2'b10;
    if (o == OP_JAL)             return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [16:0] fetch_w(input logic [6:0] o, input logic rdy);
    return e(2'b00, 2'b00, 2'b10, 2'b10, imm_of(o), 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] decode_w(input logic [6:0] o);
    return e(2'b00, 2'b01, 2'b01, 2'b00, imm_of(o), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] reset_w(input logic [6:0] o);
    return e(2'b00, 2'b00, 2'b10, 2'b10, imm_of(o), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] trap_w(input logic [6:0] o);
    return e(2'b00, 2'b00, 2'b00, 2'b00, imm_of(o), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [16:0] got_w();
    return {alu_op, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
            pc_write, ir_write, mem_write, reg_write, instr_done, halted};
  endfunction

  task automatic add(input logic [6:0] o, input logic [2:0] f, input logic z,
                     input logic r, input logic [16:0] x);
    vec_t v;
    v.op = o; v.f3 = f; v.z = z; v.rdy = r; v.exp = x;
    tbl.push_back(v);
  endtask

  task automatic check_now(input string nm, input logic [16:0] x);
    logic [16:0] g;
    g = got_w();
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, g, x);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, sample at negedge.
  task automatic cyc(input string nm, input logic [6:0] o, input logic [2:0] f,
                     input logic z, input logic r, input logic [16:0] x);
    op = o; funct3 = f; zero = z; mem_ready = r;
    @(negedge clk);
    check_now(nm, x);
    if (x[1] && rst_n) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_instret(input string nm);
    logic [31:0] want;
`ifdef PERF_INSTRET_EN
    want = exp_ret;
`else
    want = 32'h0;
`endif
    checks++;
    if (instret !== want) begin
      errors++;
      $display("FAIL %s: instret got %h expected %h", nm, instret, want);
    end
  endtask

  // Async reset asserted mid-cycle, checked while low, released after an edge.
  task automatic pulse_reset(input string nm, input logic [6:0] o);
    op = o; mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_ret = 32'h0;
    #1;
    check_now(nm, reset_w(o));
    check_instret({nm, "_instret"});
    @(posedge clk);
    #1;
    check_now({nm, "_held"}, reset_w(o));
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state: enables stay low even with mem_ready high.
    op = OP_R; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", reset_w(OP_R));
    check_instret("reset_instret");
    rst_n = 1'b1;

    // add x3,x1,x2; mem_ready low outside FETCH must be ignored
    add(OP_R, 3'b000, 1'b0, 1'b1, fetch_w(OP_R, 1'b1));
    add(OP_R, 3'b000, 1'b0, 1'b0, decode_w(OP_R));
    add(OP_R, 3'b000, 1'b0, 1'b0, e(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add(OP_R, 3'b000, 1'b0, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    // addi
    add(OP_I, 3'b000, 1'b0, 1'b1, fetch_w(OP_I, 1'b1));
    add(OP_I, 3'b000, 1'b0, 1'b1, decode_w(OP_I));
    add(OP_I, 3'b000, 1'b0, 1'b1, e(2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add(OP_I, 3'b000, 1'b0, 1'b1, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    // beq taken
    add(OP_BEQ, 3'b000, 1'b1, 1'b1, fetch_w(OP_BEQ, 1'b1));
    add(OP_BEQ, 3'b000, 1'b1, 1'b1, decode_w(OP_BEQ));
    add(OP_BEQ, 3'b000, 1'b1, 1'b1, e(2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // beq not taken
    add(OP_BEQ, 3'b000, 1'b1, 1'b1, fetch_w(OP_BEQ, 1'b1));
    add(OP_BEQ, 3'b000, 1'b1, 1'b1, decode_w(OP_BEQ));
    add(OP_BEQ, 3'b000, 1'b0, 1'b1, e(2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // jal
    add(OP_JAL, 3'b000, 1'b0, 1'b1, fetch_w(OP_JAL, 1'b1));
    add(OP_JAL, 3'b000, 1'b0, 1'b1, decode_w(OP_JAL));
    add(OP_JAL, 3'b000, 1'b0, 1'b1, e(2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add(OP_JAL, 3'b000, 1'b0, 1'b1, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    // lw: 3 waits in FETCH, 2 in MEMREAD, retires in cycle 10
    for (int i = 0; i < 3; i++) add(OP_LW, 3'b010, 1'b0, 1'b0, fetch_w(OP_LW, 1'b0));
    add(OP_LW, 3'b010, 1'b0, 1'b1, fetch_w(OP_LW, 1'b1));
    add(OP_LW, 3'b010, 1'b0, 1'b0, decode_w(OP_LW));
    add(OP_LW, 3'b010, 1'b0, 1'b0, e(2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) add(OP_LW, 3'b010, 1'b0, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add(OP_LW, 3'b010, 1'b0, 1'b1, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add(OP_LW, 3'b010, 1'b0, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    // sw: 2 waits in MEMWRITE, mem_write held 3 cycles, single retire
    add(OP_SW, 3'b010, 1'b0, 1'b1, fetch_w(OP_SW, 1'b1));
    add(OP_SW, 3'b010, 1'b0, 1'b1, decode_w(OP_SW));
    add(OP_SW, 3'b010, 1'b0, 1'b1, e(2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) add(OP_SW, 3'b010, 1'b0, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add(OP_SW, 3'b010, 1'b0, 1'b1, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec[%0d]", i), tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].rdy, tbl[i].exp);
    end
    check_instret("table_instret");

    // Unsupported opcode: TRAP is absorbing, mem_ready ignored.
    cyc("trap_fetch", OP_BAD, 3'b000, 1'b0, 1'b1, fetch_w(OP_BAD, 1'b1));
    cyc("trap_decode", OP_BAD, 3'b000, 1'b0, 1'b1, decode_w(OP_BAD));
    for (int i = 0; i < 20; i++) cyc($sformatf("trap_hold[%0d]", i), OP_BAD, 3'b000, 1'b1, 1'b1, trap_w(OP_BAD));
    pulse_reset("trap_reset", OP_R);
    cyc("after_trap_fetch", OP_R, 3'b000, 1'b0, 1'b1, fetch_w(OP_R, 1'b1));
    cyc("after_trap_decode", OP_R, 3'b000, 1'b0, 1'b1, decode_w(OP_R));
    cyc("after_trap_exec", OP_R, 3'b000, 1'b0, 1'b1, e(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("after_trap_wb", OP_R, 3'b000, 1'b0, 1'b1, e(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    check_instret("after_trap_instret");

    // beq with funct3 != 000 is unsupported.
    cyc("bne_fetch", OP_BEQ, 3'b001, 1'b1, 1'b1, fetch_w(OP_BEQ, 1'b1));
    cyc("bne_decode", OP_BEQ, 3'b001, 1'b1, 1'b1, decode_w(OP_BEQ));
    cyc("bne_trap", OP_BEQ, 3'b001, 1'b1, 1'b1, trap_w(OP_BEQ));
    pulse_reset("bne_reset", OP_SW);

    // Reset during MEMADR of a sw aborts it with no mem_write strobe.
    cyc("swrst_fetch", OP_SW, 3'b010, 1'b0, 1'b1, fetch_w(OP_SW, 1'b1));
    cyc("swrst_decode", OP_SW, 3'b010, 1'b0, 1'b1, decode_w(OP_SW));
    #1;
    check_now("swrst_memadr", e(2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pulse_reset("swrst_reset", OP_SW);
    cyc("swrst_refetch", OP_SW, 3'b010, 1'b0, 1'b0, fetch_w(OP_SW, 1'b0));
    check_instret("swrst_instret");

`ifdef PERF_INSTRET_EN
    // Counter wrap: preload all-ones, retire one beq.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_ret = 32'hFFFF_FFFF;
    check_instret("wrap_preload");
    cyc("wrap_fetch", OP_BEQ, 3'b000, 1'b0, 1'b1, fetch_w(OP_BEQ, 1'b1));
    cyc("wrap_decode", OP_BEQ, 3'b000, 1'b0, 1'b1, decode_w(OP_BEQ));
    cyc("wrap_beq", OP_BEQ, 3'b000, 1'b0, 1'b1, e(2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    checks++;
    if (instret !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_zero: instret got %h expected 00000000", instret);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
